// File: rtl/vram_pkg.sv
// Shared types and sizing helpers for the banked sprite VRAM.
package vram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clear_state_e;

  localparam int unsigned DefLanes = 8;
  localparam int unsigned DefLaneW = 16;
  localparam int unsigned DefDepth = 4096;

  function automatic int unsigned line_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned lane_aw(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vram_lane_bram.sv
// One sprite lane: simple dual-port RAM with byte write mask and registered, read-first output.
module vram_lane_bram #(
  parameter int unsigned LaneW = 16,
  parameter int unsigned Depth = 4096,
  parameter int unsigned Aw    = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [LaneW/8-1:0] be_i,
  input  logic [Aw-1:0]      waddr_i,
  input  logic [LaneW-1:0]   wdata_i,
  input  logic               re_i,
  input  logic [Aw-1:0]      raddr_i,
  output logic [LaneW-1:0]   rdata_o
);

  logic [LaneW-1:0] mem_q [Depth];
  logic [LaneW-1:0] rdata_q;

  // No reset on the array so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LaneW / 8; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vram_sprite_banked_mem.sv
// Banked sprite VRAM: narrow lane write port, whole-line read port, clear/fill engine.
// Define VRAM_READ_BYPASS_EN to forward same-cycle writes into the read result.
module vram_sprite_banked_mem
  import vram_pkg::*;
#(
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned LANE_W = DefLaneW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(DEPTH)+$clog2(LANES)-1:0] write_addr,
  input  logic [LANE_W-1:0]                      write_data,
  input  logic [LANE_W/8-1:0]                    write_be,
  input  logic                                   write_enable,
  output logic                                   write_ready,
  input  logic [$clog2(DEPTH)-1:0]               read_addr,
  input  logic                                   read_en,
  output logic [LANES*LANE_W-1:0]                read_data,
  output logic                                   read_valid,
  input  logic                                   clear_start,
  input  logic [LANE_W-1:0]                      clear_value,
  output logic                                   clear_busy,
  output logic                                   clear_done
);

  localparam int unsigned LineAw = line_aw(DEPTH);
  localparam int unsigned LaneAw = lane_aw(LANES);
  localparam int unsigned BeW    = LANE_W / 8;

  clear_state_e      state_q, state_d;
  logic [LineAw-1:0] cnt_q, cnt_d;
  logic [LANE_W-1:0] fill_q, fill_d;
  logic              read_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    write_ready = 1'b0;
    clear_busy  = 1'b0;
    clear_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        write_ready = 1'b1;
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
          fill_d  = clear_value;
        end
      end
      StClear: begin
        clear_busy = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LineAw'(DEPTH - 1)) state_d = StDone;
      end
      StDone: begin
        // Port is free again in the same cycle clear_done is reported.
        write_ready = 1'b1;
        clear_done  = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fill_q       <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      read_valid_q <= read_en;
    end
  end

  assign read_valid = read_valid_q;

  // Shared write path: the fill engine owns every lane while busy.
  logic              port_wr;
  logic [LaneAw-1:0] port_lane;
  logic [LineAw-1:0] wr_line;
  logic [LANE_W-1:0] wr_data;
  logic [BeW-1:0]    wr_be;
  logic [LANES-1:0]  lane_we;

  assign port_wr   = write_enable && write_ready;
  assign port_lane = write_addr[LaneAw-1:0];
  assign wr_line   = clear_busy ? cnt_q  : write_addr[LaneAw +: LineAw];
  assign wr_data   = clear_busy ? fill_q : write_data;
  assign wr_be     = clear_busy ? {BeW{1'b1}} : write_be;

  logic [LANES*LANE_W-1:0] lane_rdata;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_we[i] = clear_busy || (port_wr && (port_lane == LaneAw'(i)));

    vram_lane_bram #(
      .LaneW (LANE_W),
      .Depth (DEPTH),
      .Aw    (LineAw)
    ) u_lane (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (lane_we[i]),
      .be_i    (wr_be),
      .waddr_i (wr_line),
      .wdata_i (wr_data),
      .re_i    (read_en),
      .raddr_i (read_addr),
      .rdata_o (lane_rdata[i*LANE_W +: LANE_W])
    );
  end

`ifdef VRAM_READ_BYPASS_EN
  // Remember which bytes collided with the read so they override the read-first RAM data.
  logic [LANES*BeW-1:0] fwd_mask_q;
  logic [LANE_W-1:0]    fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (read_en) begin
      fwd_data_q <= wr_data;
      for (int i = 0; i < LANES; i++) begin
        fwd_mask_q[i*BeW +: BeW] <= (lane_we[i] && (wr_line == read_addr)) ? wr_be : '0;
      end
    end
  end

  always_comb begin
    read_data = lane_rdata;
    for (int i = 0; i < LANES; i++) begin
      for (int b = 0; b < BeW; b++) begin
        if (fwd_mask_q[i*BeW + b]) read_data[i*LANE_W + 8*b +: 8] = fwd_data_q[8*b +: 8];
      end
    end
  end
`else
  assign read_data = lane_rdata;
`endif

endmodule

// File: tb/tb_vram_sprite_banked_mem.sv
// Directed self-checking bench for vram_sprite_banked_mem at default sizing (8 x 16 x 4096).
module tb_vram_sprite_banked_mem;

  localparam int unsigned Lanes = 8;
  localparam int unsigned LaneW = 16;
  localparam int unsigned Depth = 4096;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [14:0]              write_addr;
  logic [LaneW-1:0]         write_data;
  logic [1:0]               write_be;
  logic                     write_enable;
  logic                     write_ready;
  logic [11:0]              read_addr;
  logic                     read_en;
  logic [Lanes*LaneW-1:0]   read_data;
  logic                     read_valid;
  logic                     clear_start;
  logic [LaneW-1:0]         clear_value;
  logic                     clear_busy;
  logic                     clear_done;

  int vectors     = 0;
  int miscompares = 0;

  vram_sprite_banked_mem #(
    .LANES  (Lanes),
    .LANE_W (LaneW),
    .DEPTH  (Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_be     (write_be),
    .write_enable (write_enable),
    .write_ready  (write_ready),
    .read_addr    (read_addr),
    .read_en      (read_en),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .clear_start  (clear_start),
    .clear_value  (clear_value),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int line, input int lane, input logic [15:0] data,
                          input logic [1:0] be);
    write_addr   = 15'((line << 3) | lane);
    write_data   = data;
    write_be     = be;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic do_read(input int line);
    read_addr = 12'(line);
    read_en   = 1'b1;
    tick();
    read_en   = 1'b0;
    check("read_valid", 128'(read_valid), 128'd1);
  endtask

  logic [127:0] exp;
  int           busy_cycles;
  int           ready_bad;
  int           done_seen;

  initial begin
    rst = 1'b1; write_addr = '0; write_data = '0; write_be = '0; write_enable = 1'b0;
    read_addr = '0; read_en = 1'b0; clear_start = 1'b0; clear_value = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst read_data", read_data, 128'd0);
    check("rst read_valid", 128'(read_valid), 128'd0);
    check("rst write_ready", 128'(write_ready), 128'd1);
    check("rst clear_busy", 128'(clear_busy), 128'd0);
    check("rst clear_done", 128'(clear_done), 128'd0);

    // Full fill with 0x5A5A, poking the port mid-fill.
    clear_value = 16'h5A5A;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_value = 16'h0000;
    busy_cycles = 0;
    ready_bad   = 0;
    while (clear_busy && busy_cycles < 5000) begin
      if (write_ready) ready_bad++;
      if (busy_cycles == 2000) begin
        write_addr = 15'd0; write_data = 16'hDEAD; write_be = 2'b11; write_enable = 1'b1;
        read_addr  = 12'd0; read_en = 1'b1;
      end else begin
        write_enable = 1'b0;
        read_en      = 1'b0;
      end
      tick();
      busy_cycles++;
      if (busy_cycles == 2001) begin
        check("read in clear valid", 128'(read_valid), 128'd1);
        check("read in clear data", read_data, {8{16'h5A5A}});
      end
    end
    write_enable = 1'b0;
    read_en      = 1'b0;
    check("fill busy cycles", 128'(busy_cycles), 128'(Depth));
    check("fill ready low", 128'(ready_bad), 128'd0);
    check("fill done pulse", 128'(clear_done), 128'd1);
    check("fill done ready", 128'(write_ready), 128'd1);
    tick();
    check("done one cycle", 128'(clear_done), 128'd0);

    do_read(0);
    check("fill line 0", read_data, {8{16'h5A5A}});
    do_read(4095);
    check("fill line 4095", read_data, {8{16'h5A5A}});

    // Lane write: line 5 lane 3 (write_addr 0x2B).
    do_write(5, 3, 16'hABCD, 2'b11);
    do_read(5);
    exp = {8{16'h5A5A}};
    exp[48 +: 16] = 16'hABCD;
    check("line5 lane3", read_data, exp);

    // Byte mask: upper byte only, then a no-op write with be=0.
    do_write(7, 0, 16'h1234, 2'b11);
    do_write(7, 0, 16'hFF00, 2'b10);
    do_read(7);
    exp = {8{16'h5A5A}};
    exp[15:0] = 16'hFF34;
    check("byte mask hi", read_data, exp);
    do_write(7, 0, 16'h9999, 2'b00);
    do_read(7);
    check("be zero no-op", read_data, exp);

    // Back-to-back reads of lines 5 and 7.
    read_addr = 12'd5; read_en = 1'b1;
    tick();
    read_addr = 12'd7;
    exp = {8{16'h5A5A}};
    exp[48 +: 16] = 16'hABCD;
    check("b2b first valid", 128'(read_valid), 128'd1);
    check("b2b first data", read_data, exp);
    tick();
    read_en = 1'b0;
    exp = {8{16'h5A5A}};
    exp[15:0] = 16'hFF34;
    check("b2b second data", read_data, exp);
    tick();
    check("valid drops", 128'(read_valid), 128'd0);
    check("data holds", read_data, exp);

    // Same-cycle write and read of line 9 lane 2.
    do_write(9, 2, 16'h1111, 2'b11);
    write_addr = 15'((9 << 3) | 2); write_data = 16'h2222; write_be = 2'b11; write_enable = 1'b1;
    read_addr  = 12'd9; read_en = 1'b1;
    tick();
    write_enable = 1'b0;
    read_en      = 1'b0;
    exp = {8{16'h5A5A}};
`ifdef VRAM_READ_BYPASS_EN
    exp[32 +: 16] = 16'h2222;
`else
    exp[32 +: 16] = 16'h1111;
`endif
    check("collision", read_data, exp);
    do_read(9);
    exp[32 +: 16] = 16'h2222;
    check("after collision", read_data, exp);

    // Reset sampled at edge 100 of a fill with 0x7777.
    clear_value = 16'h7777;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst fill busy", 128'(clear_busy), 128'd0);
    check("rst fill ready", 128'(write_ready), 128'd1);
    done_seen = clear_done ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clear_done) done_seen++;
    end
    check("rst fill no done", 128'(done_seen), 128'd0);
    do_read(50);
    check("partial fill line 50", read_data, {8{16'h7777}});
    do_read(4000);
    check("partial fill line 4000", read_data, {8{16'h5A5A}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_sprite_banked_mem.md
# vram_sprite_banked_mem

Parametrised banked sprite VRAM: a narrow pixel-pair write port from the CPU/DMA side and a wide whole-sprite-line read port for the sprite renderer. It generalises the fixed 8 × 16-bit × 4096 sprite store to configurable lane count, lane width and depth. It adds byte-granular write enables, a registered read with valid flag, and a hardware clear/fill engine. It sits between the bus write bridge and the sprite line fetcher.

## Interface
Parameters:
- LANES, 8, lanes per sprite line; power of 2, ≥2.
- LANE_W, 16, bits per lane; multiple of 8.
- DEPTH, 4096, sprite lines; power of 2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- write_addr  in  $clog2(DEPTH)+$clog2(LANES)  low $clog2(LANES) bits select the lane; high bits select the line.
- write_data  in  LANE_W  lane data.
- write_be  in  LANE_W/8  byte enables; bit k covers byte k of the lane.
- write_enable  in  1  write request.
- write_ready  out  1  write accepted this cycle when high.
- read_addr  in  $clog2(DEPTH)  line index.
- read_en  in  1  read request.
- read_data  out  LANES*LANE_W  lane i occupies bits [LANE_W*i +: LANE_W].
- read_valid  out  1  read_data updated this cycle.
- clear_start  in  1  pulse that starts a fill.
- clear_value  in  LANE_W  fill value; sampled on the accepted clear_start.
- clear_busy  out  1  fill in progress.
- clear_done  out  1  one-cycle pulse when the fill completes.

## Operation
- Storage is LANES independent lanes, each DEPTH × LANE_W with a byte write mask.
- Write: accepted when write_enable && write_ready. Only the addressed lane is written, and only the bytes whose write_be bit is set. If write_be is 0, the write is accepted with no effect.
- Read: read_en captures read_addr, and all lanes of that line are returned together.
- Clear FSM states:
  - IDLE: write_ready=1. clear_start → CLEAR; counter=0; clear_value latched.
  - CLEAR: every lane of line counter is written with the latched value and all bytes enabled; counter++. At counter==DEPTH-1, after that write, → DONE. Port writes are blocked (write_ready=0) and clear_start is ignored. Reads continue.
  - DONE: clear_done=1 for one cycle; → IDLE.
- Read/write collision on the same line in the same cycle (port write or clear write): without the macro, read-first, so the old contents are returned.
- rst: FSM → IDLE, counter cleared, outputs go to reset values. Memory contents are not cleared. Reset mid-fill leaves a partially filled memory.

## Timing
- Reset values: read_data=0, read_valid=0, write_ready=1, clear_busy=0, clear_done=0.
- Read latency is 1. read_en at edge N gives read_data and read_valid at N+1. read_valid is high for one cycle per request; read_data holds until the next read.
- Back-to-back reads at one per cycle are supported.
- A write accepted at edge N is visible to a read issued at N+1 or later.
- Fill duration: clear_start sampled at edge 0; CLEAR writes occur at edges 1..DEPTH; clear_done and write_ready=1 occur at edge DEPTH+1.
- clear_busy is high exactly while the state is CLEAR.
- clear_start in the same cycle as a port write: the write is accepted (state is IDLE) and the fill starts next cycle, so the fill overwrites that write.

## Configuration
- VRAM_READ_BYPASS_EN.
  - Defined: a collision forwards the written bytes (port or clear) into read_data for the affected lane(s), so the read returns the new data at the same latency.
  - Undefined: read-first behaviour, with no forwarding muxes.

## Structure
- Package vram_pkg:
  - clear FSM state enum (IDLE, CLEAR, DONE);
  - default LANES/LANE_W/DEPTH constants;
  - address-width helper functions.
- Sub-module vram_lane_bram: one simple dual-port lane with byte write mask and registered read. It is instantiated LANES times in a generate loop; the top holds the lane decode, the clear FSM and the forwarding logic.

## Test plan
- Write 0xABCD to lane 3 of line 5 (write_addr=0x2B, be=2'b11), then read_en at line 5 → next cycle read_valid=1 and read_data[63:48]=0xABCD, other lanes unchanged.
- Line 7 lane 0 holds 0x1234; write 0xFF00 with be=2'b10 → a read returns 0xFF34.
- clear_start with clear_value=0x5A5A → clear_busy for 4096 cycles, write_ready=0 throughout, clear_done pulses at cycle 4097, and reads of lines 0 and 4095 return all lanes 0x5A5A.
- A port write during CLEAR is not accepted and does not change memory; a read during CLEAR returns data with 1-cycle latency.
- Line 9 lane 2 holds 0x1111; in the same cycle write 0x2222 there and read line 9 → 0x1111 without the macro, 0x2222 with it.
- Assert rst at cycle 100 of a fill → next cycle clear_busy=0, write_ready=1, no clear_done pulse, and line 50 already holds the fill value.
